sdram_probe_clear: RTL and testbench

//  Sequencer owning the SDRAM command port in the menu core at power-up. Probes the installed

---
 rtl/sdram_probe_clear.sv | 188 ++++++++++++++++++
 tb/tb_sdram_probe_clear.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_probe_clear.sv
// Power-up SDRAM sequencer: sizes the module with aliasing marker writes/reads, publishes the
// result on cfg, then zero-fills the detected range with throttled single-word writes.
module sdram_probe_clear #(
  parameter int unsigned CLR_GAP  = 32,
  parameter int unsigned CLR_STEP = 2,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [15:0] mem_dout,
  output logic [26:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_we,
  output logic        mem_rd,
  output logic [15:0] cfg,
  output logic        busy,
  output logic        clear_done,
  output logic        err
);
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_P_WR, S_P_RD, S_RD_WAIT, S_GAP, S_CLEAR, S_DONE
  } state_t;

  localparam logic [27:0] STEP28 = CLR_STEP[27:0];

  state_t      r_state, w_state_n, r_ret, w_ret_n;
  logic [1:0]  r_idx, w_idx_n;
  logic [27:0] r_cnt, w_cnt_n, w_end;
  logic [31:0] r_gap, w_gap_n, r_to, w_to_n;
  logic [2:0]  r_size, w_size_n;
  logic        r_probed, w_probed_n, r_clr_done, w_clr_done_n, r_err, w_err_n, r_live;
  logic [26:0] w_mk_addr;
  logic [15:0] w_mk_data;
  logic        w_timeout;

  always_comb begin
    w_mk_addr = '0;
    w_mk_data = '0;
    case (r_idx)
      2'd0: begin w_mk_addr = 27'h4000000; w_mk_data = 16'd3128;  end
      2'd1: begin w_mk_addr = 27'h2000000; w_mk_data = 16'd2064;  end
      2'd2: begin w_mk_addr = 27'h0000000; w_mk_data = 16'd1032;  end
      default: begin w_mk_addr = 27'h1000000; w_mk_data = 16'd12345; end
    endcase
  end

  always_comb begin
    if (r_size[2])      w_end = 28'h8000000;
    else if (r_size[1]) w_end = 28'h4000000;
    else                w_end = 28'h2000000;
  end

  assign w_timeout  = !mem_ready && (r_to >= TIMEOUT - 32'd1);
  assign cfg        = {r_probed, 12'd0, r_size};
  assign busy       = r_live && (r_state != S_IDLE) && (r_state != S_DONE);
  assign clear_done = r_clr_done;
  assign err        = r_err;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_WAIT_RDY;
      r_ret      <= S_IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_gap      <= '0;
      r_to       <= '0;
      r_size     <= '0;
      r_probed   <= 1'b0;
      r_clr_done <= 1'b0;
      r_err      <= 1'b0;
      r_live     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_ret      <= w_ret_n;
      r_idx      <= w_idx_n;
      r_cnt      <= w_cnt_n;
      r_gap      <= w_gap_n;
      r_to       <= w_to_n;
      r_size     <= w_size_n;
      r_probed   <= w_probed_n;
      r_clr_done <= w_clr_done_n;
      r_err      <= w_err_n;
      r_live     <= 1'b1;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_ret_n      = r_ret;
    w_idx_n      = r_idx;
    w_cnt_n      = r_cnt;
    w_gap_n      = (r_gap >= CLR_GAP) ? r_gap : r_gap + 32'd1;
    w_to_n       = mem_ready ? r_to : r_to + 32'd1;
    w_size_n     = r_size;
    w_probed_n   = r_probed;
    w_clr_done_n = r_clr_done;
    w_err_n      = r_err;
    mem_addr     = '0;
    mem_din      = '0;
    mem_we       = 1'b0;
    mem_rd       = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_state == S_DONE) w_state_n = S_IDLE;
        if (start) begin
          w_state_n    = S_WAIT_RDY;
          w_size_n     = '0;
          w_probed_n   = 1'b0;
          w_clr_done_n = 1'b0;
          w_err_n      = 1'b0;
        end
      end
      S_WAIT_RDY: begin
        if (mem_ready) begin
          w_state_n = S_P_WR;
          w_idx_n   = 2'd0;
        end
      end
      S_P_WR: begin
        mem_addr = w_mk_addr;
        mem_din  = w_mk_data;
        if (mem_ready) begin
          mem_we    = 1'b1;
          w_state_n = S_GAP;
          w_ret_n   = (r_idx == 2'd3) ? S_P_RD : S_P_WR;
          w_idx_n   = r_idx + 2'd1;
        end
      end
      S_P_RD: begin
        mem_addr = w_mk_addr;
        if (mem_ready) begin
          mem_rd    = 1'b1;
          w_state_n = S_GAP;
          w_ret_n   = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (mem_ready) begin
          w_size_n[2'd2 - r_idx] = (mem_dout == w_mk_data);
          if (r_idx == 2'd2) begin
            w_probed_n = 1'b1;
            if (w_size_n == 3'b000) begin
              w_err_n   = 1'b1;
              w_state_n = S_DONE;
            end else begin
              w_state_n = S_CLEAR;
              w_cnt_n   = '0;
              w_gap_n   = CLR_GAP;
            end
          end else begin
            w_idx_n   = r_idx + 2'd1;
            w_state_n = S_P_RD;
          end
        end
      end
      S_GAP: w_state_n = r_ret;
      S_CLEAR: begin
        mem_addr = r_cnt[26:0];
        // r_gap counts cycles since the previous clear write; a late ready only postpones it
        if (mem_ready && (r_gap >= CLR_GAP - 32'd1)) begin
          mem_we  = 1'b1;
          w_gap_n = '0;
          w_cnt_n = r_cnt + STEP28;
          if (r_cnt + STEP28 == w_end) begin
            w_clr_done_n = 1'b1;
            w_state_n    = S_DONE;
          end else begin
            w_state_n = S_GAP;
            w_ret_n   = S_CLEAR;
          end
        end
      end
      default: w_state_n = S_WAIT_RDY;
    endcase

    if ((r_state == S_WAIT_RDY || r_state == S_P_WR || r_state == S_P_RD ||
         r_state == S_RD_WAIT || r_state == S_CLEAR) && w_timeout) begin
      w_err_n    = 1'b1;
      w_probed_n = 1'b1;
      w_state_n  = S_DONE;
    end

    if (w_state_n != r_state || mem_we || mem_rd) w_to_n = '0;
  end
endmodule

// File: tb/tb_sdram_probe_clear.sv
// Bench for sdram_probe_clear: aliasing SDRAM models with several ready behaviours, table and
// random runs checked against a marker/size reference model, plus reset/start corner sequences.
module tb_sdram_probe_clear;
  localparam int unsigned GAP  = 4;
  localparam int unsigned STEP = 32'h100000;
  localparam int unsigned TMO  = 200;
  localparam int unsigned MB32 = 32'h2000000;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_ready = 1'b1;
  logic [15:0] mem_dout = 16'h0;
  logic [26:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we, mem_rd, busy, clear_done, err;
  logic [15:0] cfg;

  sdram_probe_clear #(.CLR_GAP(GAP), .CLR_STEP(STEP), .TIMEOUT(TMO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .mem_ready(mem_ready),
    .mem_dout(mem_dout), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_rd(mem_rd), .cfg(cfg), .busy(busy), .clear_done(clear_done), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad = 0;
  int unsigned cur_size = 4 * MB32;
  int cur_mode = 0;
  int epoch = 0;
  int cyc = 0;

  int seen_epoch = 0;
  logic [15:0] mem[int unsigned];
  int n_probe_wr = 0, n_clr_wr = 0, wr_total = 0, both_hi = 0, seq_bad = 0;
  int min_sp = 1000000, last_clr_cyc = 0, post_stuck = 0, stuck_cyc = 0;
  int last_strobe_cyc = -100;
  bit stuck = 1'b0;
  logic [26:0] last_clr_addr = '0, first_clr_addr = '0;

  // ready behaviours: 0 always, 1 low 5 cycles after each strobe, 2 random, 3 dies after 2nd write
  always begin
    @(posedge clk_sys);
    cyc++;
    #1;
    case (cur_mode)
      1: mem_ready = !((cyc - last_strobe_cyc) >= 1 && (cyc - last_strobe_cyc) <= 5);
      2: mem_ready = ($urandom_range(0, 3) != 0);
      3: mem_ready = !stuck;
      default: mem_ready = 1'b1;
    endcase
  end

  always @(negedge clk_sys) begin
    int unsigned a;
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      mem.delete();
      n_probe_wr = 0; n_clr_wr = 0; wr_total = 0; both_hi = 0; seq_bad = 0;
      min_sp = 1000000; post_stuck = 0; stuck = 1'b0; last_strobe_cyc = -100;
    end
    a = (cur_size == 0) ? 0 : (32'(mem_addr) % cur_size);
    if (mem_we && mem_rd) both_hi++;
    if ((mem_we || mem_rd) && stuck) post_stuck++;
    if (mem_we || mem_rd) last_strobe_cyc = cyc;
    if (mem_we) begin
      wr_total++;
      if (cur_size != 0) mem[a] = mem_din;
      if (mem_din == 16'h0) begin
        if (n_clr_wr == 0) first_clr_addr = mem_addr;
        else if (cyc - last_clr_cyc < min_sp) min_sp = cyc - last_clr_cyc;
        if (mem_addr != 27'(n_clr_wr * STEP)) seq_bad++;
        last_clr_addr = mem_addr;
        last_clr_cyc  = cyc;
        n_clr_wr++;
      end else begin
        n_probe_wr++;
      end
      if (cur_mode == 3 && wr_total == 2) begin
        stuck = 1'b1;
        stuck_cyc = cyc;
      end
    end
    if (mem_rd) mem_dout = (cur_size == 0) ? 16'hFFFF : (mem.exists(a) ? mem[a] : 16'hA5A5);
  end

  // Reference: replay the marker protocol against an ideal aliasing memory of the given size.
  function automatic logic [15:0] model_cfg(input int unsigned size);
    logic [15:0] m[int unsigned];
    int unsigned ad[4] = '{32'h4000000, 32'h2000000, 32'h0, 32'h1000000};
    logic [15:0] mk[4] = '{16'd3128, 16'd2064, 16'd1032, 16'd12345};
    logic [15:0] r = 16'h8000;
    if (size == 0) return r;
    for (int i = 0; i < 4; i++) m[ad[i] % size] = mk[i];
    for (int i = 0; i < 3; i++) if (m[ad[i] % size] == mk[i]) r[2 - i] = 1'b1;
    return r;
  endfunction

  function automatic int unsigned model_span(input logic [15:0] c);
    if (c[2]) return 4 * MB32;
    if (c[1]) return 2 * MB32;
    if (c[0]) return MB32;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic begin_run(input int unsigned size, input int mode, input bit do_reset);
    cur_size = size;
    cur_mode = mode;
    epoch++;
    if (do_reset) begin
      reset_n = 1'b0;
      repeat (3) @(negedge clk_sys);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cfg", 32'(cfg), 0);
      chk("rst_strobes", 32'({mem_we, mem_rd}), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_flags", 32'({clear_done, err}), 0);
      reset_n = 1'b1;
    end else begin
      @(negedge clk_sys);
      start = 1'b1;
      @(negedge clk_sys);
      start = 1'b0;
    end
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk_sys);
    chk("busy_rise", 32'(busy), 1);
    chk("cfg_during_probe", 32'(cfg), 0);
  endtask

  task automatic wait_done(output int end_cyc);
    for (int i = 0; i < 30000 && busy; i++) @(negedge clk_sys);
    #1;
    chk("done_in_budget", 32'(busy), 0);
    end_cyc = cyc;
  endtask

  task automatic check_result(input logic [15:0] ecfg, input bit eerr, input bit ecd,
                              input int eclr, input int eprobe);
    chk("cfg", 32'(cfg), 32'(ecfg));
    chk("err", 32'(err), 32'(eerr));
    chk("clear_done", 32'(clear_done), 32'(ecd));
    chk("clear_writes", 32'(n_clr_wr), 32'(eclr));
    chk("probe_writes", 32'(n_probe_wr), 32'(eprobe));
    chk("we_rd_exclusive", 32'(both_hi), 0);
    if (eclr > 0) begin
      chk("first_clr_addr", 32'(first_clr_addr), 0);
      chk("last_clr_addr", 32'(last_clr_addr), 32'(27'((eclr - 1) * STEP)));
      chk("clr_sequence", 32'(seq_bad), 0);
      chk("clr_spacing_ok", 32'(min_sp >= GAP), 1);
    end
  endtask

  typedef struct {
    int unsigned size;
    int          mode;
    logic [15:0] ecfg;
    bit          eerr;
    bit          ecd;
    int          eprobe;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int end_c, eclr;
    logic [15:0] rc;
    int unsigned rs;
    tbl[0] = '{4 * MB32, 0, 16'h8007, 1'b0, 1'b1, 4};
    tbl[1] = '{MB32,     0, 16'h8001, 1'b0, 1'b1, 4};
    tbl[2] = '{2 * MB32, 1, 16'h8003, 1'b0, 1'b1, 4};
    tbl[3] = '{4 * MB32, 1, 16'h8007, 1'b0, 1'b1, 4};
    tbl[4] = '{MB32,     2, 16'h8001, 1'b0, 1'b1, 4};
    tbl[5] = '{2 * MB32, 0, 16'h8003, 1'b0, 1'b1, 4};
    tbl[6] = '{4 * MB32, 3, 16'h8000, 1'b1, 1'b0, 2};
    tbl[7] = '{0,        0, 16'h8000, 1'b1, 1'b0, 4};

    for (int i = 0; i < 8; i++) begin
      begin_run(tbl[i].size, tbl[i].mode, i == 0);
      wait_done(end_c);
      eclr = tbl[i].ecd ? int'(model_span(tbl[i].ecfg) / STEP) : 0;
      check_result(tbl[i].ecfg, tbl[i].eerr, tbl[i].ecd, eclr, tbl[i].eprobe);
      if (tbl[i].mode == 3) begin
        chk("timeout_latency_ok", 32'((end_c - stuck_cyc) >= TMO && (end_c - stuck_cyc) <= TMO + 4), 1);
        chk("no_strobe_after_stuck", 32'(post_stuck), 0);
      end
    end

    for (int i = 0; i < 4; i++) begin
      rs = MB32 << $urandom_range(0, 2);
      rc = model_cfg(rs);
      begin_run(rs, 2, 1'b0);
      wait_done(end_c);
      check_result(rc, rc[2:0] == 3'b000, rc[2:0] != 3'b000, int'(model_span(rc) / STEP), 4);
    end

    // reset pulse in the middle of the clear sweep, then a clean rerun
    begin_run(4 * MB32, 0, 1'b0);
    for (int i = 0; i < 5000 && n_clr_wr < 10; i++) @(negedge clk_sys);
    chk("reached_clear", 32'(n_clr_wr >= 10), 1);
    @(posedge clk_sys);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_strobes", 32'({mem_we, mem_rd}), 0);
    chk("async_rst_outputs", 32'({cfg, busy, clear_done, err}), 0);
    chk("async_rst_addr", 32'(mem_addr), 0);
    begin_run(4 * MB32, 0, 1'b1);
    wait_done(end_c);
    check_result(16'h8007, 1'b0, 1'b1, int'(4 * MB32 / STEP), 4);

    // start pulse while clearing must not restart the sequence
    begin_run(2 * MB32, 0, 1'b0);
    for (int i = 0; i < 5000 && n_clr_wr < 3; i++) @(negedge clk_sys);
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    wait_done(end_c);
    check_result(16'h8003, 1'b0, 1'b1, int'(2 * MB32 / STEP), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
